pipe_adder: RTL
===============

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32, is the operand and result width in bits.
REQ-002 Parameter SEGS, default 4, is the number of carry segments and pipeline stages; WIDTH % SEGS == 0 and 1 <= SEGS <= WIDTH.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  the input operands and op are valid this cycle.
REQ-006 in_ready  out  1  the block accepts input this cycle.
REQ-007 op  in  1  0 = add (a+b), 1 = subtract (a-b).
REQ-008 a, b  in  WIDTH  operands.
REQ-009 out_valid  out  1  the result fields are valid.
REQ-010 out_ready  in  1  the consumer takes the result this cycle.
REQ-011 sum  out  WIDTH  result, modulo 2^WIDTH.
REQ-012 carry  out  1  unsigned carry-out; for subtract it is NOT borrow.
REQ-013 overflow  out  1  two's-complement signed overflow.
REQ-014 zero  out  1  sum == 0.

Function
REQ-015 Segment width SW = WIDTH/SEGS; stage k (0..SEGS-1) adds segment k of a and b' plus the carry registered by stage k-1.
REQ-016 For subtract, b' = ~b and the stage-0 carry-in is 1; for add, b' = b and the carry-in is 0.
REQ-017 Operand segments not yet summed, and sum segments already produced, are carried forward in registers alongside each stage.
REQ-018 advance = !out_valid || out_ready; in_ready equals advance (combinational, no dependence on in_valid).
REQ-019 A transfer in occurs when in_valid && in_ready; a transfer out occurs when out_valid && out_ready.
REQ-020 When advance = 1, every stage register and valid bit shifts one stage; when advance = 0, all stage registers and outputs hold.
REQ-021 Latency is SEGS cycles: an input accepted at edge N appears with out_valid = 1 after edge N+SEGS, provided advance stays 1.
REQ-022 Throughput is one result per cycle while out_ready = 1; bubbles (in_valid = 0) propagate as invalid slots and are not compressed.
REQ-023 While out_valid = 1 and out_ready = 0, sum, carry, overflow and zero hold stable.
REQ-024 overflow = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]); it is computed in the last stage.
REQ-025 carry is the carry out of the last segment.
REQ-026 zero is computed from the full sum in the last stage.
REQ-027 Results leave in acceptance order, and each result is bit-exact to the single-cycle WIDTH-bit add or subtract.

Reset
REQ-028 While rst = 1 at a clock edge, all stage valid bits and out_valid clear to 0, and sum, carry, overflow and zero clear to 0.
REQ-029 Reset mid-operation discards every in-flight operation; no result for it is ever presented.
REQ-030 in_ready = 1 in the first cycle after reset deasserts.
REQ-031 Stage data registers other than the outputs need not be reset.

Structure
REQ-032 A shared package holds the op encoding constants OP_ADD = 0 and OP_SUB = 1, and the result-flag field order.
REQ-033 One sub-module, pipe_adder_seg, is the SW-bit segment add with carry-in and carry-out; it is instantiated SEGS times by generate.
REQ-034 WIDTH and SEGS legality is checked at elaboration.

Verification
REQ-035 Add, WIDTH=32, SEGS=4: a=0xFFFFFFFF, b=1 -> sum=0, carry=1, zero=1, overflow=0, after exactly 4 cycles.
REQ-036 Add: a=0x7FFFFFFF, b=1 -> sum=0x80000000, overflow=1, carry=0; subtract: a=0, b=1 -> sum=0xFFFFFFFF, carry=0, overflow=0.
REQ-037 Back-to-back: 8 consecutive random ops with out_ready=1 -> 8 in-order results on consecutive cycles, matching the reference model.
REQ-038 Stall: hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, outputs stable, no loss or duplication once out_ready returns to 1.
REQ-039 Assert rst for 1 cycle with 3 ops in flight -> out_valid=0 next cycle and none of the 3 results ever appear.
REQ-040 Repeat REQ-035..037 at WIDTH=16 SEGS=1 and WIDTH=64 SEGS=8 -> latency equals SEGS and results stay bit-exact.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the segmented pipelined adder.
//   OP_ADD / OP_SUB : encoding of the op input
//   flags_t         : result-flag field order {carry, overflow, zero}
package pipe_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } flags_t;

endpackage

// File: rtl/pipe_adder_seg.sv
// One SW-bit carry segment: {cout, sum} = a + b + cin.
//   a, b : segment operands (b already inverted for subtract)
//   cin  : carry from the previous segment
//   sum  : segment sum, cout : segment carry-out
module pipe_adder_seg #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract, split into SEGS carry segments, one per stage.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake (in_ready = pipe can advance)
//   op, a, b            : 0 = a+b, 1 = a-b
//   out_valid/out_ready : output handshake
//   sum, carry, overflow, zero : result (carry is NOT borrow for subtract)
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEGS  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int SW     = WIDTH / SEGS;
  localparam int STAGES = SEGS - 1;

  if (SEGS < 1 || SEGS > WIDTH || (WIDTH % SEGS) != 0) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a multiple of SEGS with 1 <= SEGS <= WIDTH");
  end

  logic              advance;
  logic [STAGES:0]   vld_pipe;   // vld_pipe[k] = stage k register holds a live op
  logic [WIDTH-1:0]  res_sum;
  flags_t            flags_q;

  // Whole pipe moves as one; a stalled output freezes every stage.
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (rst)          vld_pipe <= '0;
    else if (advance) vld_pipe <= (vld_pipe << 1) | (STAGES+1)'(in_valid);
  end

  // Stage k consumes the lowest remaining operand segment; its register
  // keeps only the operand segments still to be summed and the sum
  // segments produced so far, so each stage's widths differ.
  for (genvar k = 0; k < SEGS; k++) begin : g_stage
    localparam int AW = WIDTH - k*SW;

    logic [AW-1:0]         a_cur, b_cur;
    logic                  c_cur;
    logic [(k+1)*SW-1:0]   sum_cur;
    logic [SW-1:0]         s_seg;
    logic                  c_seg;

    if (k == 0) begin : g_in
      assign a_cur   = a;
      assign b_cur   = (op == OP_ADD) ? b : ~b;
      assign c_cur   = (op == OP_SUB);
      assign sum_cur = s_seg;
    end else begin : g_chain
      assign a_cur   = g_stage[k-1].g_fwd.a_q;
      assign b_cur   = g_stage[k-1].g_fwd.b_q;
      assign c_cur   = g_stage[k-1].g_fwd.c_q;
      assign sum_cur = {s_seg, g_stage[k-1].g_fwd.sum_q};
    end

    pipe_adder_seg #(.SW(SW)) u_seg (
      .a    (a_cur[SW-1:0]),
      .b    (b_cur[SW-1:0]),
      .cin  (c_cur),
      .sum  (s_seg),
      .cout (c_seg)
    );

    if (k < STAGES) begin : g_fwd
      logic [AW-SW-1:0]    a_q, b_q;
      logic                c_q;
      logic [(k+1)*SW-1:0] sum_q;

      always_ff @(posedge clk) begin
        if (advance) begin
          a_q   <= a_cur[AW-1:SW];
          b_q   <= b_cur[AW-1:SW];
          c_q   <= c_seg;
          sum_q <= sum_cur;
        end
      end
    end else begin : g_last
      // Top segment holds the operand sign bits, so signed overflow
      // is resolved here with the full sum available.
      always_ff @(posedge clk) begin
        if (rst) begin
          res_sum <= '0;
          flags_q <= '0;
        end else if (advance) begin
          res_sum          <= sum_cur;
          flags_q.carry    <= c_seg;
          flags_q.overflow <= (a_cur[SW-1] == b_cur[SW-1]) &&
                              (sum_cur[WIDTH-1] != a_cur[SW-1]);
          flags_q.zero     <= (sum_cur == '0);
        end
      end
    end
  end

  assign sum      = res_sum;
  assign carry    = flags_q.carry;
  assign overflow = flags_q.overflow;
  assign zero     = flags_q.zero;

endmodule
